// File: rtl/ierdna_resp_chk_if.sv
// ierdna_resp_chk_if -- expectation and observation bus of the ierdna
// response checker.
//
// Handshake rules (one place, applies to every signal below):
//   - exp channel: strict valid/ready. A transfer happens on a rising clk edge
//     where exp_valid && exp_ready. exp_data must be stable while exp_valid is
//     high. exp_ready depends only on registered checker state, never on
//     exp_valid.
//   - obs channel: valid-only, no backpressure. Every cycle with obs_valid high
//     delivers one observed triple; the checker cannot stall it.
//
// Signals:
//   exp_valid  master->slave  expected triple offered
//   exp_ready  slave->master  checker can accept an expected triple
//   exp_data   master->slave  expected {anao,anaid,luap}
//   obs_valid  master->slave  observed triple valid this cycle
//   obs_data   master->slave  observed {anao,anaid,luap}
interface ierdna_resp_chk_if;
  logic       exp_valid;
  logic       exp_ready;
  logic [2:0] exp_data;
  logic       obs_valid;
  logic [2:0] obs_data;

  modport master (
    output exp_valid,
    input  exp_ready,
    output exp_data,
    output obs_valid,
    output obs_data
  );

  modport slave (
    input  exp_valid,
    output exp_ready,
    input  exp_data,
    input  obs_valid,
    input  obs_data
  );
endinterface

// File: rtl/ierdna_resp_chk.sv
// ierdna_resp_chk -- response checker for the ierdna stimulus path.
//
// Expected {anao,anaid,luap} triples are queued in a DEPTH-entry FIFO. Each
// observed triple pops the head entry and is compared with it. The checker
// keeps saturating pass/fail counters, a sticky error flag, a sticky underflow
// flag and a capture of the first mismatch.
//
// Optional feature macro: IERDNA_CHK_STOP_EN
//   defined   -> entering FAILED freezes the checker (obs ignored, exp_ready=0)
//                until clear or rst.
//   undefined -> FAILED keeps counting and popping; only the first-failure
//                capture is frozen.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (priority over clear)
//   bus        slave modport: exp_valid/exp_ready/exp_data, obs_valid/obs_data
//   clear      in   synchronous clear of results; FIFO contents kept
//   pass_cnt   out  matching compares, saturating
//   fail_cnt   out  mismatching compares, saturating
//   err        out  sticky mismatch flag
//   underflow  out  sticky: obs_valid seen with the FIFO empty
//   ff_idx     out  0-based compare index of the first mismatch
//   ff_exp     out  expected value of the first mismatch
//   ff_obs     out  observed value of the first mismatch
//   state      out  00 IDLE, 01 PASSING, 10 FAILED
module ierdna_resp_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ierdna_resp_chk_if.slave bus,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             underflow,
  output logic [CNT_W-1:0] ff_idx,
  output logic [2:0]       ff_exp,
  output logic [2:0]       ff_obs,
  output logic [1:0]       state
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PASSING = 2'b01,
    FAILED  = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic [CNT_W-1:0] total_cnt;

  logic full, empty, frozen;
  logic push, pop, cmp_pass, cmp_fail, uf_hit;

  assign full  = (occ == FULL_OCC);
  assign empty = (occ == '0);

`ifdef IERDNA_CHK_STOP_EN
  assign frozen = (state_q == FAILED);
`else
  assign frozen = 1'b0;
`endif

  // Handshake decode and next-state logic.
  always_comb begin
    state_d       = state_q;
    bus.exp_ready = !full && !frozen;
    push          = bus.exp_valid && !full && !frozen;
    pop           = bus.obs_valid && !empty && !frozen;
    uf_hit        = bus.obs_valid && empty && !frozen;
    // A compare coinciding with clear still pops but is not scored.
    cmp_pass      = pop && !clear && (bus.obs_data == mem[rd_ptr]);
    cmp_fail      = pop && !clear && (bus.obs_data != mem[rd_ptr]);

    if (clear) begin
      state_d = IDLE;
    end else if (cmp_fail) begin
      state_d = FAILED;
    end else if (cmp_pass && state_q == IDLE) begin
      state_d = PASSING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign state = state_q;

  // Expected FIFO; clear leaves it untouched, rst drops its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= bus.exp_data;
  end

  // Result counters and flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      total_cnt <= '0;
      err       <= 1'b0;
      underflow <= 1'b0;
      ff_idx    <= '0;
      ff_exp    <= '0;
      ff_obs    <= '0;
    end else begin
      if (cmp_pass && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      if (cmp_fail && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
      if ((cmp_pass || cmp_fail) && total_cnt != CNT_MAX)
        total_cnt <= total_cnt + 1'b1;
      if (uf_hit) underflow <= 1'b1;
      if (cmp_fail) begin
        err <= 1'b1;
        // err is still low only on the first mismatch since rst/clear.
        if (!err) begin
          ff_idx <= total_cnt;
          ff_exp <= mem[rd_ptr];
          ff_obs <= bus.obs_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ierdna_resp_chk.sv
module tb_ierdna_resp_chk;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;
`ifdef IERDNA_CHK_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, ff_idx;
  logic err, underflow;
  logic [2:0] ff_exp, ff_obs;
  logic [1:0] state;

  ierdna_resp_chk_if bus ();

  ierdna_resp_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .err       (err),
    .underflow (underflow),
    .ff_idx    (ff_idx),
    .ff_exp    (ff_exp),
    .ff_obs    (ff_obs),
    .state     (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard: expected queue plus reference results
  logic [2:0] exp_q[$];
  int m_pass, m_fail, m_total, m_idx;
  bit m_err, m_uf;
  logic [2:0] m_fexp, m_fobs;
  int m_state; // 0 idle, 1 passing, 2 failed

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic bit model_ready();
    return (exp_q.size() < DEPTH) && !(STOP && m_state == 2);
  endfunction

  task automatic model_zero();
    m_pass = 0; m_fail = 0; m_total = 0; m_idx = 0;
    m_err = 0; m_uf = 0; m_fexp = '0; m_fobs = '0; m_state = 0;
  endtask

  task automatic check_outputs();
    chk("pass_cnt",  32'(pass_cnt),  32'(m_pass));
    chk("fail_cnt",  32'(fail_cnt),  32'(m_fail));
    chk("err",       32'(err),       32'(m_err));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("ff_idx",    32'(ff_idx),    32'(m_idx));
    chk("ff_exp",    32'(ff_exp),    32'(m_fexp));
    chk("ff_obs",    32'(ff_obs),    32'(m_fobs));
    chk("state",     32'(state),     32'(m_state));
  endtask

  // Driver: one clock cycle of stimulus, model update, then output check.
  task automatic step(input bit ev, input logic [2:0] ed, input bit ov,
                      input logic [2:0] od, input bit cl);
    bit rdy;
    logic [2:0] head;
    bus.exp_valid = ev; bus.exp_data = ed;
    bus.obs_valid = ov; bus.obs_data = od;
    clear = cl;
    rdy = model_ready();
    chk("exp_ready", 32'(bus.exp_ready), 32'(rdy));
    @(posedge clk);
    if (ov && !(STOP && m_state == 2)) begin
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        if (!cl) begin
          if (head == od) begin
            m_pass = sat_inc(m_pass);
            if (m_state == 0) m_state = 1;
          end else begin
            if (!m_err) begin
              m_idx = m_total; m_fexp = head; m_fobs = od;
            end
            m_err = 1; m_fail = sat_inc(m_fail); m_state = 2;
          end
          m_total = sat_inc(m_total);
        end
      end else begin
        m_uf = 1;
      end
    end
    if (ev && rdy) exp_q.push_back(ed);
    if (cl) model_zero();
    #1;
    check_outputs();
    bus.exp_valid = 1'b0; bus.obs_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.exp_valid = 1'b1; bus.exp_data = 3'($urandom);
    bus.obs_valid = 1'b1; bus.obs_data = 3'($urandom);
    clear = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.exp_valid = 1'b0; bus.obs_valid = 1'b0;
    exp_q.delete();
    model_zero();
    check_outputs();
    chk("reset_exp_ready", 32'(bus.exp_ready), 32'd1);
  endtask

  function automatic logic [2:0] head_or(input logic [2:0] dflt);
    return (exp_q.size() > 0) ? exp_q[0] : dflt;
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.exp_valid = 1'b0; bus.exp_data = '0;
    bus.obs_valid = 1'b0; bus.obs_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two matching compares
    step(1, 3'b101, 0, 3'b000, 0);
    step(1, 3'b010, 0, 3'b000, 0);
    step(0, 3'b000, 1, 3'b101, 0);
    step(0, 3'b000, 1, 3'b010, 0);
    chk("t1_pass", 32'(pass_cnt), 32'd2);
    chk("t1_state", 32'(state), 32'd1);

    // Single mismatch capture
    do_reset();
    step(1, 3'b111, 0, 3'b000, 0);
    step(0, 3'b000, 1, 3'b110, 0);
    chk("t2_ff_exp", 32'(ff_exp), 32'h7);
    chk("t2_ff_obs", 32'(ff_obs), 32'h6);
    chk("t2_state", 32'(state), 32'd2);

    // Full FIFO: dropped push, pop+push while full
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 3'(i + 1), 0, 3'b000, 0);
    chk("t3_full_ready", 32'(bus.exp_ready), 32'd0);
    step(1, 3'b111, 0, 3'b000, 0);
    step(1, 3'b110, 1, head_or(3'b000), 0);
    step(1, 3'b101, 0, 3'b000, 0);
    chk("t3_refull_ready", 32'(bus.exp_ready), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 3'b000, 1, head_or(3'b000), 0);

    // Underflow then normal compare
    do_reset();
    step(0, 3'b000, 1, 3'b011, 0);
    chk("t4_underflow", 32'(underflow), 32'd1);
    step(1, 3'b011, 1, 3'b000, 0);
    step(0, 3'b000, 1, head_or(3'b000), 0);

    // Saturation, then clear keeps FIFO
    do_reset();
    step(1, 3'b001, 0, 3'b000, 0);
    for (int i = 0; i < 258; i++) step(1, 3'($urandom), 1, head_or(3'b000), 0);
    chk("t5_sat", 32'(pass_cnt), 32'd255);
    step(1, 3'b100, 0, 3'b000, 1);
    chk("t5_clear_pass", 32'(pass_cnt), 32'd0);
    step(0, 3'b000, 1, head_or(3'b000), 0);
    step(0, 3'b000, 1, head_or(3'b000), 0);
    step(0, 3'b000, 1, 3'b000, 0);

    // Mismatch then two more compares (freeze behaviour depends on build)
    do_reset();
    step(1, 3'b000, 0, 3'b000, 0);
    step(1, 3'b001, 0, 3'b000, 0);
    step(1, 3'b010, 0, 3'b000, 0);
    step(0, 3'b000, 1, 3'b111, 0);
    step(0, 3'b000, 1, head_or(3'b000), 0);
    step(1, 3'b011, 1, 3'b101, 0);
    step(0, 3'b000, 0, 3'b000, 1);
    for (int i = 0; i < 4; i++) step(0, 3'b000, 1, head_or(3'b000), 0);

    // Reset in the middle of traffic drops queued expectations
    step(1, 3'b110, 0, 3'b000, 0);
    step(1, 3'b101, 0, 3'b000, 0);
    do_reset();
    step(0, 3'b000, 1, 3'b110, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit ev, ov, cl;
      logic [2:0] od;
      ev = ($urandom_range(0, 3) != 0);
      ov = ($urandom_range(0, 2) == 0);
      od = ($urandom_range(0, 7) != 0) ? head_or(3'($urandom)) : 3'($urandom);
      cl = ($urandom_range(0, 49) == 0);
      step(ev, 3'($urandom), ov, od, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
